pulse_period_meter: RTL

//  Measures the spacing between rising edges of a pulse train, counted in clk_en ticks.
//  It is the receive-side counterpart of the frequency divider: the divider turns a ratio into a

---
 rtl/pulse_period_meter_if.sv | 21 ++
 rtl/pulse_period_meter.sv | 125 ++++++++++++
 2 files changed

// File: rtl/pulse_period_meter_if.sv
// pulse_period_meter_if
//   Result channel of the pulse period meter. The producer offers a period
//   value with valid; the consumer takes it with ready.
//   Handshake: a transfer happens on any clk edge where valid && ready are
//   both 1. Once raised, valid stays 1 and period stays stable until a
//   transfer occurs. The one exception is a newer measurement, which may
//   replace period while valid is held.
//   Signals:
//     period  producer -> consumer  measured rising-edge spacing
//     valid   producer -> consumer  period holds an unconsumed measurement
//     ready   consumer -> producer  consumer accepts period this cycle
interface pulse_period_meter_if #(
   parameter int CNT_BITS = 8
);
   logic [CNT_BITS-1:0] period;
   logic                valid;
   logic                ready;

   modport master (output period, output valid, input ready);
   modport slave  (input period, input valid, output ready);
endinterface

// File: rtl/pulse_period_meter.sv
// pulse_period_meter
//   Measures the spacing between rising edges of a pulse train, counted in
//   clk_en ticks. Each completed period is offered on the res channel.
//   Ports:
//     clk        system clock, posedge
//     reset      asynchronous active-low reset
//     clk_en     tick qualifier; state (edge detector included) holds when 0
//     en         measurement enable; 0 forces IDLE and clears the flags
//     in         pulse input, synchronous to clk
//     res        result channel (period / valid / ready), master side
//     overflow   sticky: a spacing exceeded 2^CNT_BITS-1 ticks
//     missed     sticky: a result overwrote an unconsumed one
//     busy       1 while measuring (state MEASURE)
//     state_dbg  current FSM state encoding
module pulse_period_meter #(
   parameter int CNT_BITS = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      clk_en,
   input  logic                      en,
   input  logic                      in,
   pulse_period_meter_if.master      res,
   output logic                      overflow,
   output logic                      missed,
   output logic                      busy,
   output logic [1:0]                state_dbg
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      MEASURE = 2'd2
   } state_t;

   localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
   localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

   state_t              state;
   logic [CNT_BITS-1:0] cnt;
   logic                in_d;
   logic                rise;
   logic                xfer;
   logic                new_res;

   // Edge detection only counts on tick cycles; in_d holds otherwise.
   assign rise    = clk_en & in & ~in_d;
   assign xfer    = res.valid & res.ready;
   assign new_res = rise & (state == MEASURE);

   assign state_dbg = state;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         cnt        <= '0;
         in_d       <= 1'b0;
         res.period <= '0;
         res.valid  <= 1'b0;
         overflow   <= 1'b0;
         missed     <= 1'b0;
         busy       <= 1'b0;
      end else begin
         // in_d keeps tracking while disabled so re-enabling with in high
         // does not look like a fresh rising edge.
         if (clk_en) in_d <= in;

         if (!en) begin
            // Disable acts on every edge, ticked or not; period keeps its value.
            state     <= IDLE;
            cnt       <= '0;
            res.valid <= 1'b0;
            overflow  <= 1'b0;
            missed    <= 1'b0;
            busy      <= 1'b0;
         end else begin
            // Output channel: runs on every edge, independent of clk_en.
            // A result arriving together with a transfer replaces the consumed
            // value without counting as a miss.
            if (new_res) begin
               res.period <= cnt;
               res.valid  <= 1'b1;
               if (res.valid && !xfer) missed <= 1'b1;
            end else if (xfer) begin
               res.valid <= 1'b0;
            end

            if (clk_en) begin
               case (state)
                  IDLE: begin
                     state <= ARMED;
                     busy  <= 1'b0;
                  end
                  ARMED: begin
                     if (rise) begin
                        cnt   <= CNT_ONE;
                        state <= MEASURE;
                        busy  <= 1'b1;
                     end
                  end
                  MEASURE: begin
                     if (rise) begin
                        cnt <= CNT_ONE;
                     end else if (cnt == CNT_MAX) begin
                        // Spacing too long to represent: drop it and wait
                        // for the next rise to start over.
                        overflow <= 1'b1;
                        cnt      <= '0;
                        state    <= ARMED;
                        busy     <= 1'b0;
                     end else begin
                        cnt <= cnt + CNT_ONE;
                     end
                  end
                  default: begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               endcase
            end
         end
      end
   end

endmodule
